// File: rtl/fpu.sv
// fpu: binary32 adder/subtractor, multi-cycle FSM with ready/ack handshake.
// Define FPU_SPECIAL_VALUES_EN for NaN/infinity handling and denormal support.
module fpu (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  command,
  input  logic [31:0] data_a,
  input  logic [31:0] data_b,
  input  logic        input_rdy,
  output logic        input_ack,
  output logic        output_rdy,
  input  logic        output_ack,
  output logic [31:0] result
);
  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADDSUB, NORMALIZE, ROUND, PACK, DONE} state_t;
  state_t state;
  logic [31:0] a_r, b_r;
  logic sub_r, sa, sb, sr, eff_sub;
  logic [7:0] ea, eb;
  logic [23:0] ma, mb, mg, rm;
  logic signed [9:0] er;
  logic [26:0] al, mn;
  logic [27:0] sum;
  logic sb_n;
  logic [7:0] ea_n, eb_n;
  logic [23:0] ma_n, mb_n;
  assign sb_n = b_r[31] ^ sub_r;
`ifdef FPU_SPECIAL_VALUES_EN
  logic spec;
  logic [31:0] spec_val;
  logic nan_a, nan_b, inf_a, inf_b, spec_n;
  logic [31:0] spec_val_n;
  assign ea_n = a_r[30:23] == 8'd0 ? 8'd1 : a_r[30:23];
  assign eb_n = b_r[30:23] == 8'd0 ? 8'd1 : b_r[30:23];
  assign ma_n = {a_r[30:23] != 8'd0, a_r[22:0]};
  assign mb_n = {b_r[30:23] != 8'd0, b_r[22:0]};
  assign nan_a = &a_r[30:23] & |a_r[22:0];
  assign nan_b = &b_r[30:23] & |b_r[22:0];
  assign inf_a = &a_r[30:23] & ~|a_r[22:0];
  assign inf_b = &b_r[30:23] & ~|b_r[22:0];
  assign spec_n = nan_a | nan_b | inf_a | inf_b;
  assign spec_val_n = (nan_a | nan_b | (inf_a & inf_b & (a_r[31] != sb_n))) ? 32'h7FC00000 :
                      inf_a ? {a_r[31], 8'hFF, 23'd0} : {sb_n, 8'hFF, 23'd0};
`else
  assign ea_n = a_r[30:23];
  assign eb_n = b_r[30:23];
  assign ma_n = a_r[30:23] == 8'd0 ? 24'd0 : {1'b1, a_r[22:0]};
  assign mb_n = b_r[30:23] == 8'd0 ? 24'd0 : {1'b1, b_r[22:0]};
`endif
  // Alignment: larger magnitude becomes the reference, smaller is shifted with guard/round/sticky
  logic swap;
  logic [7:0] eg, es, d;
  logic [23:0] ms;
  logic [26:0] ext, al_n;
  assign swap = {eb, mb} > {ea, ma};
  assign eg = swap ? eb : ea;
  assign es = swap ? ea : eb;
  assign ms = swap ? ma : mb;
  assign d = eg - es;
  assign ext = {ms, 3'b000};
  assign al_n = d >= 8'd26 ? {26'd0, |ms} : (ext >> d) | {26'd0, |(ext & ~({27{1'b1}} << d))};
  logic [27:0] sum_n;
  assign sum_n = eff_sub ? {1'b0, mg, 3'b000} - {1'b0, al} : {1'b0, mg, 3'b000} + {1'b0, al};
  logic [4:0] lz, sh;
  always_comb begin
    lz = 5'd27;
    for (int i = 0; i < 27; i++) lz = sum[i] ? 5'(26 - i) : lz;
  end
`ifdef FPU_SPECIAL_VALUES_EN
  // Stop the left shift at exponent 1 so underflowing results land as exact denormals
  assign sh = (er - 10'sd1) < $signed({5'd0, lz}) ? 5'(er - 10'sd1) : lz;
`else
  assign sh = lz;
`endif
  logic [26:0] mn_n;
  logic signed [9:0] en_n;
  assign mn_n = sum[27] ? {sum[27:2], sum[1] | sum[0]} : sum[26:0] << sh;
  assign en_n = sum[27] ? er + 10'sd1 : er - $signed({5'd0, sh});
  logic up;
  logic [24:0] r25;
  assign up = mn[2] & (mn[3] | mn[1] | mn[0]);
  assign r25 = {1'b0, mn[26:3]} + {24'd0, up};
  logic [31:0] res_n;
`ifdef FPU_SPECIAL_VALUES_EN
  assign res_n = spec ? spec_val : er >= 10'sd255 ? {sr, 8'hFF, 23'd0} :
                 {sr, rm[23] ? er[7:0] : 8'd0, rm[22:0]};
`else
  assign res_n = er >= 10'sd255 ? {sr, 8'hFF, 23'd0} :
                 (er < 10'sd1 || !rm[23]) ? {sr, 31'd0} : {sr, er[7:0], rm[22:0]};
`endif
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      input_ack <= 1'b0;
      output_rdy <= 1'b0;
      result <= 32'h0;
      a_r <= 32'h0;
      b_r <= 32'h0;
      sub_r <= 1'b0;
      sa <= 1'b0;
      sb <= 1'b0;
      sr <= 1'b0;
      eff_sub <= 1'b0;
      ea <= 8'd0;
      eb <= 8'd0;
      ma <= 24'd0;
      mb <= 24'd0;
      mg <= 24'd0;
      rm <= 24'd0;
      er <= 10'sd0;
      al <= 27'd0;
      mn <= 27'd0;
      sum <= 28'd0;
`ifdef FPU_SPECIAL_VALUES_EN
      spec <= 1'b0;
      spec_val <= 32'h0;
`endif
    end else
      case (state)
        IDLE: if (input_rdy) begin
          a_r <= data_a;
          b_r <= data_b;
          sub_r <= command == 4'd1;
          input_ack <= 1'b1;
          state <= UNPACK;
        end
        UNPACK: begin
          sa <= a_r[31];
          sb <= sb_n;
          ea <= ea_n;
          eb <= eb_n;
          ma <= ma_n;
          mb <= mb_n;
`ifdef FPU_SPECIAL_VALUES_EN
          spec <= spec_n;
          spec_val <= spec_val_n;
`endif
          state <= ALIGN;
        end
        ALIGN: begin
          mg <= swap ? mb : ma;
          sr <= swap ? sb : sa;
          eff_sub <= sa ^ sb;
          er <= $signed({2'b00, eg});
          al <= al_n;
          state <= ADDSUB;
        end
        ADDSUB: begin
          sum <= sum_n;
          sr <= (eff_sub && sum_n == 28'd0) ? 1'b0 : sr;
          state <= NORMALIZE;
        end
        NORMALIZE: begin
          mn <= mn_n;
          er <= en_n;
          state <= ROUND;
        end
        ROUND: begin
          rm <= r25[24] ? r25[24:1] : r25[23:0];
          er <= er + $signed({9'd0, r25[24]});
          state <= PACK;
        end
        PACK: begin
          result <= res_n;
          output_rdy <= 1'b1;
          state <= DONE;
        end
        DONE: if (output_ack) begin
          output_rdy <= 1'b0;
          input_ack <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_fpu.sv
// tb_fpu: directed vectors with a result scoreboard checked by an independent monitor.
module tb_fpu;
  logic clock = 1'b0, reset = 1'b0, input_rdy = 1'b0, output_ack = 1'b0;
  logic [3:0] command = 4'd0;
  logic [31:0] data_a = 32'h0, data_b = 32'h0;
  logic input_ack, output_rdy;
  logic [31:0] result;
  int n_cmp = 0, n_bad = 0;
  typedef struct {string name; logic [31:0] val;} exp_t;
  exp_t expq[$];
  exp_t cur;
  bit seen = 1'b0;

  fpu dut (
    .clock(clock), .reset(reset), .command(command), .data_a(data_a), .data_b(data_b),
    .input_rdy(input_rdy), .input_ack(input_ack), .output_rdy(output_rdy),
    .output_ack(output_ack), .result(result)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!output_rdy) seen = 1'b0;
    else if (!seen) begin
      seen = 1'b1;
      if (expq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got %h, expected no output", result);
      end else begin
        cur = expq.pop_front();
        check(cur.name, result, cur.val);
      end
    end
  end

  task automatic op(input string name, input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] exp, input int hold, input bit early_ack);
    int lat;
    expq.push_back('{name, exp});
    @(negedge clock);
    command = cmd;
    data_a = a;
    data_b = b;
    input_rdy = 1'b1;
    @(posedge clock);
    #1;
    input_rdy = 1'b0;
    lat = 1;
    check({name, "_iack"}, 32'(input_ack), 32'd1);
    if (early_ack) output_ack = 1'b1;
    while (!output_rdy && lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check({name, "_latency"}, lat, 32'd7);
    check({name, "_iack_done"}, 32'(input_ack), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clock);
      #1;
      check({name, "_hold_rdy"}, 32'(output_rdy), 32'd1);
      check({name, "_hold_result"}, result, exp);
    end
    if (early_ack) begin
      @(negedge clock);
      check({name, "_rdy_one_cycle"}, 32'(output_rdy), 32'd1);
    end
    @(negedge clock);
    output_ack = 1'b1;
    @(posedge clock);
    #1;
    output_ack = 1'b0;
    check({name, "_rdy_drop"}, 32'(output_rdy), 32'd0);
    check({name, "_iack_drop"}, 32'(input_ack), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    #1;
    check("reset_result", result, 32'h0);
    check("reset_rdy", 32'(output_rdy), 32'd0);
    check("reset_iack", 32'(input_ack), 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    op("add_plain", 4'd0, 32'h3F800000, 32'b0_01111000_01000111101011100001010,
       32'b0_01111111_00000010100011110101110, 20, 1'b0);
    op("add_carry", 4'd0, 32'b0_10000011_10100000000000000000000, 32'b0_10000011_11010000000000000000000,
       32'b0_10000100_10111000000000000000000, 0, 1'b0);
    op("add_round_binade", 4'd0, 32'b0_01100111_10101101011111110010101,
       32'b0_01111110_11111111111111111111110, 32'h3F800000, 0, 1'b0);
    op("sub_cancel", 4'd1, 32'h40400000, 32'h40000000, 32'h3F800000, 0, 1'b0);
    op("sub_self", 4'd1, 32'h40400000, 32'h40400000, 32'h00000000, 0, 1'b0);
    op("sub_negative", 4'd1, 32'h40000000, 32'h40400000, 32'hBF800000, 0, 1'b0);
    op("add_cmd7_early_ack", 4'd7, 32'h3F800000, 32'h40000000, 32'h40400000, 0, 1'b1);
    op("add_zero_operand", 4'd0, 32'h00000000, 32'h40000000, 32'h40000000, 0, 1'b0);
    op("overflow", 4'd0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 0, 1'b0);
`ifdef FPU_SPECIAL_VALUES_EN
    op("underflow", 4'd1, 32'h00800001, 32'h00800000, 32'h00000001, 0, 1'b0);
    op("inf_minus_inf", 4'd0, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 0, 1'b0);
`else
    op("underflow", 4'd1, 32'h00800001, 32'h00800000, 32'h00000000, 0, 1'b0);
    op("exp255_finite", 4'd0, 32'h7F800000, 32'hFF800000, 32'h00000000, 0, 1'b0);
`endif
    @(negedge clock);
    command = 4'd0;
    data_a = 32'h3F800000;
    data_b = 32'h3F800000;
    input_rdy = 1'b1;
    @(posedge clock);
    #1 input_rdy = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check("abort_result", result, 32'h0);
    check("abort_rdy", 32'(output_rdy), 32'd0);
    check("abort_iack", 32'(input_ack), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (12) @(posedge clock);
    #1;
    check("abort_no_output", 32'(output_rdy), 32'd0);
    op("after_abort", 4'd0, 32'h40000000, 32'h40000000, 32'h40800000, 0, 1'b0);
    repeat (3) @(posedge clock);
    check("pending_results", expq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
